// File: rtl/uart_rx_packer.sv
// rtl/uart_rx_packer.sv - 8N1 UART receiver that packs bytes into DATA_W-bit RX FIFO words
module uart_rx_packer #(
  parameter int CLKS_PER_BIT      = 434,
  parameter int DATA_W            = 24,
  parameter int IDLE_TIMEOUT_BITS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_in,
  output logic [DATA_W-1:0]               rx_data,
  output logic [$clog2(DATA_W/8+1)-1:0]   rx_nbytes,
  output logic                            rx_wren,
  input  logic                            rx_full,
  output logic                            framing_err,
  output logic                            overrun,
  input  logic                            clr_err,
  output logic                            busy
);

  localparam int BYTES   = DATA_W / 8;
  localparam int NB_W    = $clog2(BYTES + 1);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [NB_W-1:0]   FULL_CNT    = NB_W'(BYTES);
  localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic              rx_s1_q;
  logic              rxs_q;
  state_e            state_q;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              framing_err_q;

  logic [DATA_W-1:0] asm_data_q, asm_data_d;
  logic [NB_W-1:0]   asm_cnt_q, asm_cnt_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [NB_W-1:0]   hold_nbytes_q, hold_nbytes_d;
  logic              hold_valid_q, hold_valid_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              overrun_q, overrun_d;

  logic commit, start_det, asm_full, asm_nonempty, pop, drop, flush_due, move;

  // Preset to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      rx_s1_q <= rx_in;
      rxs_q   <= rx_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      framing_err_q <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= S_BREAK;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign commit       = (state_q == S_STOP) && (clk_cnt_q == BIT_LAST) && rxs_q;
  assign start_det    = (state_q == S_IDLE) && !rxs_q;
  assign asm_full     = (asm_cnt_q == FULL_CNT);
  assign asm_nonempty = (asm_cnt_q != '0);
  assign pop          = hold_valid_q && !rx_full;
  assign drop         = commit && asm_full && hold_valid_q;
  assign flush_due    = asm_nonempty && (asm_full || (idle_cnt_q == TIMEOUT_CNT));
  // Holding must already be empty; a word popped this cycle frees it for the next
  assign move         = flush_due && !hold_valid_q;

  always_comb begin
    asm_data_d    = asm_data_q;
    asm_cnt_d     = asm_cnt_q;
    hold_data_d   = hold_data_q;
    hold_nbytes_d = hold_nbytes_q;
    hold_valid_d  = hold_valid_q;
    idle_cnt_d    = idle_cnt_q;
    overrun_d     = (overrun_q && !clr_err) || drop;

    if (pop) begin
      hold_valid_d  = 1'b0;
      hold_data_d   = '0;
      hold_nbytes_d = '0;
    end
    if (move) begin
      hold_valid_d  = 1'b1;
      hold_data_d   = asm_data_q;
      hold_nbytes_d = asm_cnt_q;
      asm_data_d    = '0;
      asm_cnt_d     = '0;
    end
    if (commit && !drop) begin
      for (int i = 0; i < BYTES; i++) begin
        if (asm_cnt_d == NB_W'(i)) asm_data_d[i*8 +: 8] = shift_q;
      end
      asm_cnt_d = asm_cnt_d + NB_W'(1);
    end

    if (commit || start_det || !asm_nonempty || move) begin
      idle_cnt_d = '0;
    end else if ((state_q == S_IDLE) && (idle_cnt_q != TIMEOUT_CNT)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_data_q    <= '0;
      asm_cnt_q     <= '0;
      hold_data_q   <= '0;
      hold_nbytes_q <= '0;
      hold_valid_q  <= 1'b0;
      idle_cnt_q    <= '0;
      overrun_q     <= 1'b0;
    end else begin
      asm_data_q    <= asm_data_d;
      asm_cnt_q     <= asm_cnt_d;
      hold_data_q   <= hold_data_d;
      hold_nbytes_q <= hold_nbytes_d;
      hold_valid_q  <= hold_valid_d;
      idle_cnt_q    <= idle_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_wren     = pop;
  assign rx_data     = hold_data_q;
  assign rx_nbytes   = hold_nbytes_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE) || asm_nonempty || hold_valid_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb/tb_uart_rx_packer.sv - self-checking bench for uart_rx_packer with a word-level reference model
module tb_uart_rx_packer;

  localparam int CPB   = 8;
  localparam int TO    = 4;
  localparam int BYTES = 3;
  // Write edge of a completed word, counted from the first clock edge that sees the start bit
  localparam int LAT_FULL = 10 * CPB - CPB / 2 + 4;
  localparam int STOP_OFS = 10 * CPB - CPB / 2 + 2;

  logic        clk;
  logic        rst;
  logic        rx_in;
  logic [23:0] rx_data;
  logic [1:0]  rx_nbytes;
  logic        rx_wren;
  logic        rx_full;
  logic        framing_err;
  logic        overrun;
  logic        clr_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_start = 0;
  int fe_count = 0;

  logic [23:0] got_data[$];
  logic [1:0]  got_nb[$];
  int          got_cyc[$];
  logic [23:0] exp_data[$];
  logic [1:0]  exp_nb[$];
  logic [7:0]  burst[$];

  uart_rx_packer #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(24),
    .IDLE_TIMEOUT_BITS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_nbytes(rx_nbytes),
    .rx_wren(rx_wren),
    .rx_full(rx_full),
    .framing_err(framing_err),
    .overrun(overrun),
    .clr_err(clr_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_wren) begin
      got_data.push_back(rx_data);
      got_nb.push_back(rx_nbytes);
      got_cyc.push_back(cyc + 1);
    end
    if (framing_err) fe_count = fe_count + 1;
  end

  // Caller is at a negedge; returns at a negedge with the stop level still driven
  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx_in = 1'b0;
    last_start = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop_v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs;
    got_data.delete();
    got_nb.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_nb.delete();
    fe_count = 0;
  endtask

  // Reference packing: little-endian lanes, chunks of BYTES, trailing partial chunk flushed with zero upper lanes
  task automatic model_burst(input int max_bytes);
    int n;
    n = (burst.size() < max_bytes) ? burst.size() : max_bytes;
    for (int i = 0; i < n; i += BYTES) begin
      logic [23:0] w;
      int cnt;
      w = 24'h0;
      cnt = 0;
      for (int j = 0; j < BYTES; j++) begin
        if (i + j < n) begin
          w = w | (24'(burst[i+j]) << (8 * j));
          cnt++;
        end
      end
      exp_data.push_back(w);
      exp_nb.push_back(2'(cnt));
    end
  endtask

  task automatic compare_words(input string tag);
    n_checks++;
    if (got_data.size() !== exp_data.size())
      begin n_errors++; $display("FAIL %s word_count got %0d expected %0d", tag, got_data.size(), exp_data.size()); end
    for (int i = 0; i < exp_data.size(); i++) begin
      n_checks++;
      if (i >= got_data.size()) begin
        n_errors++; $display("FAIL %s word%0d missing expected %h/%0d", tag, i, exp_data[i], exp_nb[i]);
      end else if (got_data[i] !== exp_data[i] || got_nb[i] !== exp_nb[i]) begin
        n_errors++; $display("FAIL %s word%0d got %h/%0d expected %h/%0d", tag, i, got_data[i], got_nb[i], exp_data[i], exp_nb[i]);
      end
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({rx_data, rx_nbytes, rx_wren, framing_err, overrun, busy} !== 30'h0)
      begin n_errors++; $display("FAIL reset_outputs got data=%h nb=%0d wren=%b fe=%b ovr=%b busy=%b expected all 0", rx_data, rx_nbytes, rx_wren, framing_err, overrun, busy); end
  endtask

  task automatic test_back_to_back;
    clear_obs();
    burst = '{8'h11, 8'h22, 8'h33};
    foreach (burst[i]) send_byte(burst[i], 1'b1);
    idle(20);
    model_burst(100);
    compare_words("b2b");
    n_checks++;
    if (got_cyc.size() > 0 && got_cyc[0] !== last_start + LAT_FULL)
      begin n_errors++; $display("FAIL b2b_latency got edge %0d expected %0d", got_cyc[0], last_start + LAT_FULL); end
    n_checks++;
    if (fe_count !== 0) begin n_errors++; $display("FAIL b2b_framing got %0d expected 0", fe_count); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy got %b expected 0", busy); end
  endtask

  task automatic test_timeout;
    int stop_edge;
    clear_obs();
    burst = '{8'hA5};
    send_byte(8'hA5, 1'b1);
    stop_edge = last_start + STOP_OFS;
    idle(60);
    model_burst(100);
    compare_words("timeout");
    n_checks++;
    if (got_cyc.size() > 0 && (got_cyc[0] < stop_edge + TO * CPB || got_cyc[0] > stop_edge + TO * CPB + 4))
      begin n_errors++; $display("FAIL timeout_delay got %0d expected %0d..%0d", got_cyc[0] - stop_edge, TO * CPB, TO * CPB + 4); end
  endtask

  task automatic test_overrun;
    clear_obs();
    burst.delete();
    for (int i = 1; i <= 9; i++) burst.push_back(8'(i));
    rx_full = 1'b1;
    foreach (burst[i]) send_byte(burst[i], 1'b1);
    idle(60);
    n_checks++;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set got %b expected 1", overrun); end
    n_checks++;
    if (got_data.size() !== 0) begin n_errors++; $display("FAIL ovr_no_write_while_full got %0d expected 0", got_data.size()); end
    rx_full = 1'b0;
    idle(10);
    model_burst(2 * BYTES);
    compare_words("ovr");
    n_checks++;
    if (overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky got %b expected 1", overrun); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL ovr_dropped_not_kept busy got %b expected 0", busy); end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    n_checks++;
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_clear got %b expected 0", overrun); end
  endtask

  task automatic test_framing;
    clear_obs();
    send_byte(8'h55, 1'b0);
    repeat (30) @(negedge clk);
    idle(16);
    burst = '{8'h3C};
    send_byte(8'h3C, 1'b1);
    idle(60);
    model_burst(100);
    compare_words("framing");
    n_checks++;
    if (fe_count !== 1) begin n_errors++; $display("FAIL framing_pulse got %0d cycles expected 1", fe_count); end
  endtask

  task automatic test_glitch;
    clear_obs();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(24);
    n_checks++;
    if (fe_count !== 0 || got_data.size() !== 0 || busy !== 1'b0)
      begin n_errors++; $display("FAIL glitch got fe=%0d words=%0d busy=%b expected 0/0/0", fe_count, got_data.size(), busy); end
  endtask

  task automatic test_reset_mid;
    clear_obs();
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    rx_in = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_before got %b expected 1", busy); end
    #2 rst = 1'b0;
    rx_in = 1'b1;
    #1;
    n_checks++;
    if ({rx_data, rx_nbytes, rx_wren, framing_err, overrun, busy} !== 30'h0)
      begin n_errors++; $display("FAIL rstmid_outputs got data=%h nb=%0d wren=%b fe=%b ovr=%b busy=%b expected all 0", rx_data, rx_nbytes, rx_wren, framing_err, overrun, busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(4);
    clear_obs();
    burst = '{8'hC1, 8'hD2, 8'hE3};
    foreach (burst[i]) send_byte(burst[i], 1'b1);
    idle(60);
    model_burst(100);
    compare_words("rstmid");
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      int n;
      clear_obs();
      burst.delete();
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) burst.push_back(8'($urandom));
      foreach (burst[i]) begin
        send_byte(burst[i], 1'b1);
        idle($urandom_range(0, 10));
      end
      idle(60);
      model_burst(100);
      compare_words("random");
    end
  endtask

  initial begin
    rst     = 1'b0;
    rx_in   = 1'b1;
    rx_full = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    idle(4);
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
